// File: rtl/line_div_pkg.sv
// Shared constants and helpers for the scan-line divider.
// Used by line_clk_div; no build macros here.
package line_div_pkg;

   localparam int DEF_DIV_N      = 2;
   localparam int DEF_HIGH_LINES = 1;

   // A one-phase counter still needs a bit, so clamp to a minimum of 1.
   function automatic int phase_width(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/line_clk_div.sv
// Scan-line qualifier: clk_div is high on the last HIGH_LINES lines of every DIV_N-line period.
// Define LINE_CLK_DIV_PHASE_EN to expose the phase counter as line_phase.
module line_clk_div
   import line_div_pkg::*;
#(
   parameter  int DIV_N      = DEF_DIV_N,
   parameter  int HIGH_LINES = DEF_HIGH_LINES,
   localparam int PHASE_W    = phase_width(DIV_N)
) (
   input  logic               hsync_r_pos,
   input  logic               rst_n,
`ifdef LINE_CLK_DIV_PHASE_EN
   output logic [PHASE_W-1:0] line_phase,
`endif
   output logic               clk_div
);

   generate
      if (DIV_N < 2 || DIV_N > 1023) begin : g_bad_div_n
         $error("line_clk_div: DIV_N=%0d outside 2..1023", DIV_N);
      end
      if (HIGH_LINES < 1 || HIGH_LINES >= DIV_N) begin : g_bad_high_lines
         $error("line_clk_div: HIGH_LINES=%0d outside 1..DIV_N-1", HIGH_LINES);
      end
   endgenerate

   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DIV_N - 1);
   localparam logic [PHASE_W-1:0] HIGH_START = PHASE_W'(DIV_N - HIGH_LINES);

   logic [PHASE_W-1:0] r_phase;
   logic               r_clk_div;
   logic [PHASE_W-1:0] w_phase_next;
   logic               w_high_next;

   always_comb begin
      w_phase_next = (r_phase == LAST_PHASE) ? '0 : r_phase + PHASE_W'(1);
      w_high_next  = (w_phase_next >= HIGH_START);
   end

   // Qualifier is decided from the phase being entered, so it is valid right after the edge.
   always_ff @(posedge hsync_r_pos or negedge rst_n) begin
      if (!rst_n) begin
         r_phase   <= '0;
         r_clk_div <= 1'b0;
      end else begin
         r_phase   <= w_phase_next;
         r_clk_div <= w_high_next;
      end
   end

   assign clk_div = r_clk_div;

`ifdef LINE_CLK_DIV_PHASE_EN
   assign line_phase = r_phase;
`endif

endmodule

// File: tb/tb_line_clk_div.sv
// Directed bench for line_clk_div: three parameter sets share one hsync clock and reset.
// Phase outputs are also checked when LINE_CLK_DIV_PHASE_EN is defined.
module tb_line_clk_div;

   logic hsync_r_pos = 1'b0;
   logic rst_n       = 1'b0;
   logic d2, d4, d5;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef LINE_CLK_DIV_PHASE_EN
   logic [0:0] p2;
   logic [1:0] p4;
   logic [2:0] p5;
`endif

   line_clk_div u_div2 (
      .hsync_r_pos (hsync_r_pos),
      .rst_n       (rst_n),
`ifdef LINE_CLK_DIV_PHASE_EN
      .line_phase  (p2),
`endif
      .clk_div     (d2)
   );

   line_clk_div #(.DIV_N(4), .HIGH_LINES(1)) u_div4 (
      .hsync_r_pos (hsync_r_pos),
      .rst_n       (rst_n),
`ifdef LINE_CLK_DIV_PHASE_EN
      .line_phase  (p4),
`endif
      .clk_div     (d4)
   );

   line_clk_div #(.DIV_N(5), .HIGH_LINES(3)) u_div5 (
      .hsync_r_pos (hsync_r_pos),
      .rst_n       (rst_n),
`ifdef LINE_CLK_DIV_PHASE_EN
      .line_phase  (p5),
`endif
      .clk_div     (d5)
   );

   // Rising edges at 5, 15, 25 ...; sampling happens on falling edges.
   always #5 hsync_r_pos = ~hsync_r_pos;

   // Hand-derived: clk_div follows the phase entered on each edge.
   int exp2 [10] = '{1,0,1,0,1,0,1,0,1,0};
   int exp4 [10] = '{0,0,1,0,0,0,1,0,0,0};
   int exp5 [10] = '{0,1,1,1,0,0,1,1,1,0};
   int ph4  [10] = '{1,2,3,0,1,2,3,0,1,2};
   int ph5  [10] = '{1,2,3,4,0,1,2,3,4,0};

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset held across two edges.
      repeat (2) @(negedge hsync_r_pos);
      chk("rst_d2", int'(d2), 0);
      chk("rst_d4", int'(d4), 0);
      chk("rst_d5", int'(d5), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(negedge hsync_r_pos);
         chk($sformatf("run_d2[%0d]", i), int'(d2), exp2[i]);
         chk($sformatf("run_d4[%0d]", i), int'(d4), exp4[i]);
         chk($sformatf("run_d5[%0d]", i), int'(d5), exp5[i]);
`ifdef LINE_CLK_DIV_PHASE_EN
         chk($sformatf("run_p2[%0d]", i), int'(p2), (i + 1) % 2);
         chk($sformatf("run_p4[%0d]", i), int'(p4), ph4[i]);
         chk($sformatf("run_p5[%0d]", i), int'(p5), ph5[i]);
`endif
      end

      // Edge 11: d2 phase 1 (high), d4 phase 3 (high), d5 phase 1 (low).
      @(negedge hsync_r_pos);
      chk("pre_rst_d2", int'(d2), 1);
      chk("pre_rst_d4", int'(d4), 1);
      chk("pre_rst_d5", int'(d5), 0);

      // Asynchronous drop between edges.
      #2 rst_n = 1'b0;
      #1;
      chk("async_d2", int'(d2), 0);
      chk("async_d4", int'(d4), 0);

      for (int i = 0; i < 3; i++) begin
         @(negedge hsync_r_pos);
         chk($sformatf("hold_d2[%0d]", i), int'(d2), 0);
         chk($sformatf("hold_d4[%0d]", i), int'(d4), 0);
         chk($sformatf("hold_d5[%0d]", i), int'(d5), 0);
`ifdef LINE_CLK_DIV_PHASE_EN
         chk($sformatf("hold_p4[%0d]", i), int'(p4), 0);
         chk($sformatf("hold_p5[%0d]", i), int'(p5), 0);
`endif
      end
      rst_n = 1'b1;

      // Counting restarts from phase 0.
      for (int i = 0; i < 4; i++) begin
         @(negedge hsync_r_pos);
         chk($sformatf("rel_d2[%0d]", i), int'(d2), exp2[i]);
         chk($sformatf("rel_d4[%0d]", i), int'(d4), exp4[i]);
         chk($sformatf("rel_d5[%0d]", i), int'(d5), exp5[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
